fib_table: RTL and testbench

// Forwarding Information Base of the NDN router, between the PIT and the network interface.

---
 rtl/fib_table.sv | 218 +++++++++++++++++++++
 tb/tb_fib_table.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fib_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fib_table: NDN Forwarding Information Base. Longest-prefix match of PIT     |
// | interests against prefixes learned from Data packets, plus the Data offer  |
// | / stream handshake towards the PIT.                                        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fib_table #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] pit_in_prefix,
    input  logic [5:0]  pit_in_len,
    input  logic        fib_out_bit,
    input  logic        start_send_to_pit,
    input  logic        rejected,
    input  logic [63:0] data_in_prefix,
    input  logic [5:0]  data_in_len,
    input  logic        data_ready,
    input  logic [7:0]  data_in,
    output logic [63:0] pit_out_prefix,
    output logic [5:0]  pit_out_len,
    output logic        prefix_ready,
    output logic [7:0]  out_data,
    output logic [63:0] prefix_out,
    output logic [5:0]  len_out,
    output logic        clk_out
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_STREAM = 3'd3;
    localparam logic [2:0] S_DROP   = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ended_q, ended_d;
    logic [PTR_W-1:0] rr_q, rr_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [63:0]      tprefix_q [DEPTH];
    logic [63:0]      tprefix_d [DEPTH];
    logic [5:0]       tlen_q [DEPTH];
    logic [5:0]       tlen_d [DEPTH];
    logic [63:0]      int_prefix_q, int_prefix_d;
    logic [5:0]       int_len_q, int_len_d;
    logic [63:0]      pit_out_prefix_q, pit_out_prefix_d;
    logic [5:0]       pit_out_len_q, pit_out_len_d;
    logic             prefix_ready_q, prefix_ready_d;
    logic [7:0]       out_data_q, out_data_d;
    logic [63:0]      prefix_out_q, prefix_out_d;
    logic [5:0]       len_out_q, len_out_d;
    logic             clk_out_q, clk_out_d;

    logic [DEPTH-1:0] hit_vec, dup_vec;
    logic             has_free;
    logic [PTR_W-1:0] free_idx, ins_idx;
    logic             pkt_ended;

    function automatic logic [63:0] prefix_mask(input logic [5:0] len);
        return ~({64{1'b1}} >> len);
    endfunction

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        assign hit_vec[i] = valid_q[i] && (tlen_q[i] <= int_len_q) &&
                            (((tprefix_q[i] ^ int_prefix_q) & prefix_mask(tlen_q[i])) == 64'd0);
        assign dup_vec[i] = valid_q[i] && (tprefix_q[i] == data_in_prefix) &&
                            (tlen_q[i] == data_in_len);
    end

    // Lowest-indexed free slot; descending scan so the last write wins.
    always_comb begin
        has_free = 1'b0;
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_free = 1'b1;
                free_idx = PTR_W'(i);
            end
        end
    end

    assign ins_idx   = has_free ? free_idx : rr_q;
    assign pkt_ended = ended_q || !data_ready;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        ended_d          = ended_q;
        rr_d             = rr_q;
        valid_d          = valid_q;
        tprefix_d        = tprefix_q;
        tlen_d           = tlen_q;
        int_prefix_d     = int_prefix_q;
        int_len_d        = int_len_q;
        pit_out_prefix_d = pit_out_prefix_q;
        pit_out_len_d    = pit_out_len_q;
        out_data_d       = out_data_q;
        prefix_out_d     = prefix_out_q;
        len_out_d        = len_out_q;
        clk_out_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (data_ready) begin
                    pit_out_prefix_d = data_in_prefix;
                    pit_out_len_d    = data_in_len;
                    cnt_d            = '0;
                    ended_d          = 1'b0;
                    state_d          = S_WAIT;
                    if (dup_vec == '0) begin
                        valid_d[ins_idx]   = 1'b1;
                        tprefix_d[ins_idx] = data_in_prefix;
                        tlen_d[ins_idx]    = data_in_len;
                        if (!has_free) begin
                            rr_d = (rr_q == PTR_W'(DEPTH - 1)) ? '0 : rr_q + 1'b1;
                        end
                    end
                end else if (fib_out_bit) begin
                    int_prefix_d = pit_in_prefix;
                    int_len_d    = pit_in_len;
                    state_d      = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                // The forwarded name is the interest itself, so only hit/miss matters here.
                if (hit_vec != '0) begin
                    prefix_out_d = int_prefix_q;
                    len_out_d    = int_len_q;
                    clk_out_d    = 1'b1;
                end
                state_d = S_IDLE;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!data_ready) begin
                    ended_d = 1'b1;
                end
                if (rejected) begin
                    state_d = pkt_ended ? S_IDLE : S_DROP;
                end else if (start_send_to_pit) begin
                    state_d = pkt_ended ? S_IDLE : S_STREAM;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = pkt_ended ? S_IDLE : S_DROP;
                end
            end
            S_STREAM: begin
                if (data_ready) begin
                    out_data_d = data_in;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DROP: begin
                if (!data_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        prefix_ready_d = (state_d == S_WAIT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= S_IDLE;
            cnt_q            <= '0;
            ended_q          <= 1'b0;
            rr_q             <= '0;
            valid_q          <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tprefix_q[i] <= '0;
                tlen_q[i]    <= '0;
            end
            int_prefix_q     <= '0;
            int_len_q        <= '0;
            pit_out_prefix_q <= '0;
            pit_out_len_q    <= '0;
            prefix_ready_q   <= 1'b0;
            out_data_q       <= '0;
            prefix_out_q     <= '0;
            len_out_q        <= '0;
            clk_out_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            ended_q          <= ended_d;
            rr_q             <= rr_d;
            valid_q          <= valid_d;
            tprefix_q        <= tprefix_d;
            tlen_q           <= tlen_d;
            int_prefix_q     <= int_prefix_d;
            int_len_q        <= int_len_d;
            pit_out_prefix_q <= pit_out_prefix_d;
            pit_out_len_q    <= pit_out_len_d;
            prefix_ready_q   <= prefix_ready_d;
            out_data_q       <= out_data_d;
            prefix_out_q     <= prefix_out_d;
            len_out_q        <= len_out_d;
            clk_out_q        <= clk_out_d;
        end
    end

    assign pit_out_prefix = pit_out_prefix_q;
    assign pit_out_len    = pit_out_len_q;
    assign prefix_ready   = prefix_ready_q;
    assign out_data       = out_data_q;
    assign prefix_out     = prefix_out_q;
    assign len_out        = len_out_q;
    assign clk_out        = clk_out_q;

endmodule
`default_nettype wire

// File: tb/tb_fib_table.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fib_table: scoreboard bench for fib_table (forwards and streamed bytes). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fib_table;
    localparam int C_DEPTH   = 8;
    localparam int C_TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pit_in_prefix = '0;
    logic [5:0]  pit_in_len = '0;
    logic        fib_out_bit = 1'b0;
    logic        start_send_to_pit = 1'b0;
    logic        rejected = 1'b0;
    logic [63:0] data_in_prefix = '0;
    logic [5:0]  data_in_len = '0;
    logic        data_ready = 1'b0;
    logic [7:0]  data_in = '0;
    logic [63:0] pit_out_prefix;
    logic [5:0]  pit_out_len;
    logic        prefix_ready;
    logic [7:0]  out_data;
    logic [63:0] prefix_out;
    logic [5:0]  len_out;
    logic        clk_out;

    fib_table #(.DEPTH(C_DEPTH), .TIMEOUT(C_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .pit_in_prefix(pit_in_prefix), .pit_in_len(pit_in_len), .fib_out_bit(fib_out_bit),
        .start_send_to_pit(start_send_to_pit), .rejected(rejected),
        .data_in_prefix(data_in_prefix), .data_in_len(data_in_len),
        .data_ready(data_ready), .data_in(data_in),
        .pit_out_prefix(pit_out_prefix), .pit_out_len(pit_out_len),
        .prefix_ready(prefix_ready), .out_data(out_data),
        .prefix_out(prefix_out), .len_out(len_out), .clk_out(clk_out)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [69:0] exp_fwd [$];
    logic [7:0]  exp_byte [$];
    logic [7:0]  last_out = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every clk_out pulse and every out_data change must match the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            last_out = out_data;
        end else begin
            if (clk_out) begin
                n_tests++;
                if (exp_fwd.size() == 0) begin
                    n_fail++;
                    $display("FAIL fwd_unexpected: prefix_out=%h len_out=%0d, none expected", prefix_out, len_out);
                end else begin
                    logic [69:0] e;
                    e = exp_fwd.pop_front();
                    if ({prefix_out, len_out} !== e) begin
                        n_fail++;
                        $display("FAIL fwd_value: got %h/%0d expected %h/%0d", prefix_out, len_out, e[69:6], e[5:0]);
                    end
                end
            end
            if (out_data !== last_out) begin
                n_tests++;
                if (exp_byte.size() == 0) begin
                    n_fail++;
                    $display("FAIL byte_unexpected: out_data=%h, none expected", out_data);
                end else begin
                    logic [7:0] b;
                    b = exp_byte.pop_front();
                    if (out_data !== b) begin
                        n_fail++;
                        $display("FAIL byte_value: got %h expected %h", out_data, b);
                    end
                end
                last_out = out_data;
            end
        end
    end

    task automatic interest(input logic [63:0] p, input logic [5:0] l, input bit hit);
        pit_in_prefix = p;
        pit_in_len    = l;
        fib_out_bit   = 1'b1;
        if (hit) exp_fwd.push_back({p, l});
        tick;
        fib_out_bit = 1'b0;
        tick;
        tick;
        tick;
        chk("fwd_drained", 64'(exp_fwd.size()), 64'd0);
    endtask

    // mode 0 accept+stream, 1 reject, 2 timeout; collide issues an interest alongside
    task automatic data_pkt(input logic [63:0] p, input logic [5:0] l, input int mode,
                            input int nbytes, input logic [7:0] b0, input bit collide);
        int cnt;
        data_in_prefix = p;
        data_in_len    = l;
        data_ready     = 1'b1;
        data_in        = 8'hEE;
        if (collide) begin
            pit_in_prefix = p;
            pit_in_len    = 6'd16;
            fib_out_bit   = 1'b1;
        end
        tick;
        fib_out_bit = 1'b0;
        chk("prdy_rise", 64'(prefix_ready), 64'd1);
        chk("pit_out_prefix", pit_out_prefix, p);
        chk("pit_out_len", 64'(pit_out_len), 64'(l));
        if (mode == 0) begin
            start_send_to_pit = 1'b1;
            tick;
            start_send_to_pit = 1'b0;
            chk("prdy_fall_accept", 64'(prefix_ready), 64'd0);
            for (int k = 0; k < nbytes; k++) begin
                data_in = b0 + 8'(k * 8'h11);
                exp_byte.push_back(data_in);
                tick;
            end
        end else if (mode == 1) begin
            rejected          = 1'b1;
            start_send_to_pit = 1'b1;
            pit_in_prefix     = p;
            pit_in_len        = l;
            fib_out_bit       = 1'b1;
            tick;
            rejected          = 1'b0;
            start_send_to_pit = 1'b0;
            fib_out_bit       = 1'b0;
            chk("prdy_fall_reject", 64'(prefix_ready), 64'd0);
            data_in = 8'h5A;
            tick;
            tick;
        end else begin
            cnt = 1;
            for (int k = 0; k < 4 * C_TIMEOUT; k++) begin
                tick;
                if (!prefix_ready) break;
                cnt++;
            end
            chk("timeout_cycles", 64'(cnt), 64'(C_TIMEOUT));
        end
        data_ready = 1'b0;
        tick;
        tick;
        chk("bytes_drained", 64'(exp_byte.size()), 64'd0);
    endtask

    function automatic logic [63:0] p8(input logic [7:0] b);
        return {b, 56'd0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tick;
        tick;
        chk("rst_prefix_ready", 64'(prefix_ready), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        rst = 1'b1;
        tick;
        chk("rst_pit_out_prefix", pit_out_prefix, 64'd0);
        chk("rst_pit_out_len", 64'(pit_out_len), 64'd0);
        chk("rst_prefix_out", prefix_out, 64'd0);
        chk("rst_len_out", 64'(len_out), 64'd0);
        chk("rst_clk_out", 64'(clk_out), 64'd0);
        interest(p8(8'hAB), 6'd8, 1'b0);

        data_pkt(p8(8'hAB), 6'd8, 0, 3, 8'h11, 1'b0);
        interest(64'hABCD_0000_0000_0000, 6'd16, 1'b1);
        interest(64'hAC00_0000_0000_0000, 6'd16, 1'b0);
        interest(p8(8'hAB), 6'd4, 1'b0);

        data_pkt(p8(8'hA0), 6'd4, 0, 2, 8'h44, 1'b0);
        interest(64'hA500_0000_0000_0000, 6'd16, 1'b1);
        interest(64'hAB00_0000_0000_0000, 6'd16, 1'b1);

        data_pkt(p8(8'h12), 6'd8, 1, 0, 8'h00, 1'b0);
        chk("out_data_hold_reject", 64'(out_data), 64'h55);
        interest(p8(8'h12), 6'd8, 1'b1);

        data_pkt(p8(8'h34), 6'd8, 2, 0, 8'h00, 1'b0);
        interest(p8(8'h34), 6'd8, 1'b1);
        chk("prefix_out_hold", prefix_out, p8(8'h34));

        data_pkt(p8(8'hAB), 6'd8, 1, 0, 8'h00, 1'b1);

        // Asynchronous reset while a packet is being offered.
        data_in_prefix = p8(8'h99);
        data_in_len    = 6'd8;
        data_ready     = 1'b1;
        tick;
        chk("midop_prdy_before", 64'(prefix_ready), 64'd1);
        rst = 1'b0;
        #1;
        chk("midop_prdy_after", 64'(prefix_ready), 64'd0);
        chk("midop_pit_out_prefix", pit_out_prefix, 64'd0);
        data_ready = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        interest(64'hAB00_0000_0000_0000, 6'd16, 1'b0);
        interest(p8(8'h99), 6'd8, 1'b0);

        for (int i = 0; i <= C_DEPTH; i++) begin
            data_pkt(p8(8'h30 + 8'(i)), 6'd8, 1, 0, 8'h00, 1'b0);
        end
        interest(p8(8'h30), 6'd8, 1'b0);
        interest(p8(8'h31), 6'd8, 1'b1);
        interest(p8(8'h38), 6'd8, 1'b1);
        data_pkt(p8(8'h31), 6'd8, 1, 0, 8'h00, 1'b0);
        data_pkt(p8(8'h39), 6'd8, 1, 0, 8'h00, 1'b0);
        interest(p8(8'h31), 6'd8, 1'b0);
        interest(p8(8'h32), 6'd8, 1'b1);
        interest(p8(8'h38), 6'd8, 1'b1);
        interest(p8(8'h39), 6'd8, 1'b1);

        tick;
        chk("final_fwd_queue", 64'(exp_fwd.size()), 64'd0);
        chk("final_byte_queue", 64'(exp_byte.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
